// File: rtl/passcode_writer_pkg.sv
// Shared lock definitions: code layout, reset code and the writer state encoding.
// The checker and the writer both import this so they agree on digit order.
package passcode_writer_pkg;

    localparam int DIGIT_W     = 2;
    localparam int NUM_DIGITS  = 3;
    localparam int CODE_W      = NUM_DIGITS * DIGIT_W;
    localparam int TIMEOUT_CYC = 1000;

    localparam logic [CODE_W-1:0] DEFAULT_CODE = 6'b01_10_11;

    typedef enum logic [2:0] {
        IDLE,
        ENTER_NEW,
        CONFIRM,
        COMMIT,
        ERROR
    } writer_state_e;

endpackage

// File: rtl/passcode_writer_enter_edge.sv
// Registers the raw enter button once and emits a one-cycle pulse on its rising edge.
// Shared with the checker so both sides count presses identically.
module enter_edge (
    input  logic clk,
    input  logic rst,
    input  logic enter,
    output logic press
);

    logic enter_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_q <= 1'b0;
        end else begin
            enter_q <= enter;
        end
    end

    assign press = enter & ~enter_q;

endmodule

// File: rtl/passcode_writer.sv
// Passcode programming FSM: captures a code twice, commits it only when both entries match.
// code feeds the checker's compare input; led_prog/confirm_phase/done/err drive the UI.
module passcode_writer #(
    parameter int                               NUM_DIGITS   = passcode_writer_pkg::NUM_DIGITS,
    parameter int                               DIGIT_W      = passcode_writer_pkg::DIGIT_W,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]    DEFAULT_CODE = passcode_writer_pkg::DEFAULT_CODE,
    parameter int                               TIMEOUT_CYC  = passcode_writer_pkg::TIMEOUT_CYC
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mode,
    input  logic [DIGIT_W-1:0]              digit,
    input  logic                            enter,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   code,
    output logic [NUM_DIGITS-1:0]           led_prog,
    output logic                            confirm_phase,
    output logic                            done,
    output logic                            err
);

    import passcode_writer_pkg::*;

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYC > 0);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

    writer_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic [CODE_W-1:0]  shadow_a_q, shadow_a_d;
    logic [CODE_W-1:0]  shadow_b_q, shadow_b_d;
    logic               load_code;
    logic               press;
    logic               timeout;

    enter_edge u_enter_edge (
        .clk   (clk),
        .rst   (rst),
        .enter (enter),
        .press (press)
    );

    // Expiry fires on the idle cycle that would make the idle count reach TIMEOUT_CYC.
    assign timeout = TO_EN && (tcnt_q == TO_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        tcnt_d        = tcnt_q;
        shadow_a_d    = shadow_a_q;
        shadow_b_d    = shadow_b_q;
        load_code     = 1'b0;
        led_prog      = '0;
        confirm_phase = 1'b0;
        done          = 1'b0;
        err           = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tcnt_d = '0;
                if (mode) begin
                    state_d = ENTER_NEW;
                end
            end

            ENTER_NEW, CONFIRM: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    led_prog[i] = (cnt_q > CNT_W'(i));
                end
                confirm_phase = (state_q == CONFIRM);

                // Priority: abort, then end-of-pass, then a press, then timeout expiry.
                if (!mode) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_FULL) begin
                    cnt_d  = '0;
                    tcnt_d = '0;
                    if (state_q == ENTER_NEW) begin
                        state_d = CONFIRM;
                    end else if (shadow_a_q == shadow_b_q) begin
                        state_d   = COMMIT;
                        load_code = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end else if (press) begin
                    cnt_d  = cnt_q + 1'b1;
                    tcnt_d = '0;
                    if (state_q == ENTER_NEW) begin
                        shadow_a_d = (shadow_a_q << DIGIT_W) | CODE_W'(digit);
                    end else begin
                        shadow_b_d = (shadow_b_q << DIGIT_W) | CODE_W'(digit);
                    end
                end else if (timeout) begin
                    state_d = ERROR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            COMMIT: begin
                done    = 1'b1;
                cnt_d   = '0;
                tcnt_d  = '0;
                state_d = mode ? ENTER_NEW : IDLE;
            end

            ERROR: begin
                err = 1'b1;
                if (!mode) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            // NOTE: the shadows are plain registers, not a RAM, so clearing them on reset is free.
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            code       <= DEFAULT_CODE;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            if (load_code) begin
                code <= shadow_a_q;
            end
        end
    end

endmodule
